// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: finish a multiply as soon as the remaining multiplier bits are zero.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               stallreq,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH+1:0] hilo_bus,
  output logic               div_by_zero
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state;
  logic [5:0]     cnt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   divisor;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           neg_q;
  logic           neg_r;
  logic           dbz;

  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_abs;
  logic [W-1:0]   b_abs;
  logic           last_iter;
  logic           mul_last;
  logic [2*W-1:0] prod_add;
  logic [2*W-1:0] mul_res;
  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic           fits;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   quo_res;
  logic [W-1:0]   rem_res;

  always_comb begin
    a_neg     = op[0] & src_a[W-1];
    b_neg     = op[0] & src_b[W-1];
    a_abs     = a_neg ? -src_a : src_a;
    b_abs     = b_neg ? -src_b : src_b;
    last_iter = (cnt == 6'(W-1));
    prod_add  = mplier[0] ? prod + mcand : prod;
    mul_res   = neg_q ? -prod_add : prod_add;
`ifdef MDU_EARLY_OUT_EN
    mul_last  = last_iter | (mplier[W-1:1] == '0);
`else
    mul_last  = last_iter;
`endif
    // The partial remainder is below the divisor, so one extra bit covers the shifted value.
    shifted   = {rem, quo[W-1]};
    trial     = shifted - {1'b0, divisor};
    fits      = ~trial[W];
    rem_next  = fits ? trial[W-1:0] : shifted[W-1:0];
    quo_next  = {quo[W-2:0], fits};
    quo_res   = neg_q ? -quo_next : quo_next;
    rem_res   = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            cnt   <= '0;
            dbz   <= 1'b0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (!op[1]) begin
              mcand  <= {{W{1'b0}}, a_abs};
              mplier <= b_abs;
              prod   <= '0;
              state  <= MUL;
            end else if (src_b == '0) begin
              hi    <= src_a;
              lo    <= '1;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              rem     <= '0;
              quo     <= a_abs;
              divisor <= b_abs;
              state   <= DIV;
            end
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            prod   <= prod_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
            if (mul_last) begin
              {hi, lo} <= mul_res;
              state    <= DONE;
            end
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 6'd1;
            if (last_iter) begin
              lo    <= quo_res;
              hi    <= rem_res;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush arriving in DONE cancels that cycle's write, so done is gated combinationally.
  assign done        = ~rst & (state == DONE) & ~flush;
  assign busy        = ~rst & (state != IDLE);
  assign stallreq    = ~rst & (((state == IDLE) & start & ~flush) | (state == MUL) | (state == DIV));
  assign hilo_bus    = done ? {2'b11, hi, lo} : '0;
  assign div_by_zero = done & dbz;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table plus flush/reset/hold sequences.
// Expected multiply latency follows MDU_EARLY_OUT_EN when the bench is built with it.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [65:0] hilo_bus;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[15];

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .src_a(src_a),
    .src_b(src_b),
    .flush(flush),
    .stallreq(stallreq),
    .busy(busy),
    .done(done),
    .hilo_bus(hilo_bus),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Cycles from acceptance to the done pulse.
  function automatic int expLatency(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
    int iters;
`endif
    if (o[1]) return (b == 32'd0) ? 1 : 33;
`ifdef MDU_EARLY_OUT_EN
    m = (o[0] && b[31]) ? -b : b;
    iters = 1;
    for (int i = 0; i < 32; i++) if (m[i]) iters = i + 1;
    return iters + 1;
`else
    return 33;
`endif
  endfunction

  task automatic waitDone(output int lat, output logic [65:0] bus, output logic dbz,
                          output int stall_cnt, output logic stall_at_done);
    logic seen;
    seen = 1'b0;
    lat = 0;
    bus = '0;
    dbz = 1'b0;
    stall_cnt = 1;
    stall_at_done = 1'b1;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      op    = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      #1;
      if (done) begin
        seen = 1'b1;
        lat = n;
        bus = hilo_bus;
        dbz = div_by_zero;
        stall_at_done = stallreq;
      end else if (stallreq) begin
        stall_cnt++;
      end
    end
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int lat;
    int stall_cnt;
    logic [65:0] bus;
    logic dbz;
    logic sad;
    int exp_lat;
    exp_lat = expLatency(v.op, v.b);
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    src_a = v.a;
    src_b = v.b;
    #1;
    checkOutput($sformatf("v%0d stall_accept", idx), 66'(stallreq), 66'(1));
    waitDone(lat, bus, dbz, stall_cnt, sad);
    checkOutput($sformatf("v%0d latency", idx), 66'(lat), 66'(exp_lat));
    checkOutput($sformatf("v%0d stall_cycles", idx), 66'(stall_cnt), 66'(exp_lat));
    checkOutput($sformatf("v%0d stall_at_done", idx), 66'(sad), 66'(0));
    checkOutput($sformatf("v%0d hilo_bus", idx), bus, {2'b11, v.hi, v.lo});
    checkOutput($sformatf("v%0d div_by_zero", idx), 66'(dbz), 66'(v.dbz));
    @(negedge clk);
    #1;
    checkOutput($sformatf("v%0d busy_after", idx), 66'(busy), 66'(0));
    checkOutput($sformatf("v%0d done_after", idx), 66'(done), 66'(0));
    checkOutput($sformatf("v%0d bus_after", idx), hilo_bus, 66'(0));
  endtask

  initial begin
    int lat;
    int stall_cnt;
    logic [65:0] bus;
    logic dbz;
    logic sad;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b00, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0};
    vecs[9]  = '{2'b01, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
    vecs[10] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[12] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[13] = '{2'b11, 32'h80000000, 32'd2,        32'd0,        32'hC0000000, 1'b0};
    vecs[14] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};

    // Reset with start high: everything must read zero.
    rst = 1'b1; start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst stallreq", 66'(stallreq), 66'(0));
    checkOutput("rst busy", 66'(busy), 66'(0));
    checkOutput("rst done", 66'(done), 66'(0));
    checkOutput("rst bus", hilo_bus, 66'(0));
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_rst busy", 66'(busy), 66'(0));

    for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
    #1;
    checkOutput("idle_flush stallreq", 66'(stallreq), 66'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("idle_flush busy", 66'(busy), 66'(0));

    // DIV accepted at T, flushed at T+10, MULTU 2x3 accepted at T+11.
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 10) flush = 1'b1;
      #1;
      checkOutput($sformatf("flush10 done_c%0d", n), 66'(done), 66'(0));
    end
    @(negedge clk);
    flush = 1'b0; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
    #1;
    checkOutput("flush10 busy", 66'(busy), 66'(0));
    checkOutput("flush10 bus", hilo_bus, 66'(0));
    checkOutput("flush10 restart_stall", 66'(stallreq), 66'(1));
    waitDone(lat, bus, dbz, stall_cnt, sad);
    checkOutput("flush10 latency", 66'(lat), 66'(expLatency(2'b00, 32'd3)));
    checkOutput("flush10 hilo_bus", bus, {2'b11, 32'd0, 32'd6});

    // Flush during the DONE cycle suppresses the pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
    lat = expLatency(2'b00, 32'd3);
    for (int n = 1; n < lat; n++) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("done_flush busy", 66'(busy), 66'(1));
    checkOutput("done_flush done", 66'(done), 66'(0));
    checkOutput("done_flush bus", hilo_bus, 66'(0));
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("done_flush busy_after", 66'(busy), 66'(0));
    checkOutput("done_flush done_after", 66'(done), 66'(0));

    // Synchronous reset in the middle of a multiply drops it.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd11; src_b = 32'hFFFF0000;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    checkOutput("midrst stallreq", 66'(stallreq), 66'(0));
    checkOutput("midrst busy", 66'(busy), 66'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst busy_after", 66'(busy), 66'(0));
    repeat (40) begin
      @(negedge clk);
      #1;
      checkOutput("midrst no_done", 66'(done), 66'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
